// File: rtl/fifo_decimation_pkg.sv
// Shared types and sizing helpers for the decimating Avalon-MM FIFO writer.
package fifo_decimation_pkg;

    // Avalon-MM write sequencer states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } wr_state_e;

    localparam int SAMPLE_W_DEFAULT   = 16;
    localparam int DECIM_LOG2_DEFAULT = 2;
    localparam int DECIM_FACTOR       = 32'sd1 <<< DECIM_LOG2_DEFAULT;
    localparam int ACC_W              = SAMPLE_W_DEFAULT + DECIM_LOG2_DEFAULT;

    // Number of samples averaged per output value
    function automatic int decim_factor(input int log2);
        return 32'sd1 <<< log2;
    endfunction

    // Accumulator width that holds a full group sum without overflow
    function automatic int acc_width(input int sample_w, input int log2);
        return sample_w + log2;
    endfunction

endpackage

// File: rtl/fifo_decimation_word_buffer.sv
// Small synchronous circular buffer of packed output words.
// Exposes the head and the entry behind it so the writer can preload the
// next word in the same cycle the head is popped.
module fifo_decimation_word_buffer
    import fifo_decimation_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic [W-1:0]                 push_data,
    input  logic                         pop,
    output logic [W-1:0]                 head,
    output logic [W-1:0]                 second,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_r [DEPTH];
    logic [PW-1:0] wr_ptr_r;
    logic [PW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;

    // Storage, pointers and occupancy; pointers wrap naturally (DEPTH is 2**n)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PW'(1'b1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PW'(1'b1);
            end
            count_r <= count_r + CW'(push) - CW'(pop);
        end
    end

    assign head   = mem_r[rd_ptr_r];
    assign second = mem_r[rd_ptr_r + PW'(1'b1)];
    assign count  = count_r;
    assign full   = (count_r == CW'(DEPTH));
    assign empty  = (count_r == {CW{1'b0}});

endmodule

// File: rtl/fifo_decimation_avmm_writer.sv
// Boxcar-decimates a signed sample stream, packs two averages per word and
// writes the words to the decimation FIFO's Avalon-MM write slave.
module fifo_decimation_avmm_writer
    import fifo_decimation_pkg::*;
#(
    parameter int SAMPLE_W   = 16,
    parameter int DECIM_LOG2 = 2,
    parameter int BUF_DEPTH  = 4,
    parameter int OUT_W      = 32
) (
    input  logic                wrclock,
    input  logic                wrreset,
    input  logic                enable,
    input  logic [SAMPLE_W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                avm_write,
    output logic [OUT_W-1:0]    avm_writedata,
    input  logic                avm_waitrequest,
    output logic [15:0]         words_written
);

    localparam int ACC_W_L = acc_width(SAMPLE_W, DECIM_LOG2);
    localparam int CNT_W   = $clog2(BUF_DEPTH + 1);

    logic signed [ACC_W_L-1:0] acc_r;
    logic signed [ACC_W_L-1:0] sample_ext_s;
    logic signed [ACC_W_L-1:0] sum_s;
    logic [DECIM_LOG2-1:0]     grp_cnt_r;
    logic [SAMPLE_W-1:0]       avg_s;
    logic [SAMPLE_W-1:0]       half_r;
    logic                      half_valid_r;
    logic                      accept_s;
    logic                      group_done_s;
    logic                      push_s;
    logic                      pop_s;
    logic [OUT_W-1:0]          push_word_s;
    logic [OUT_W-1:0]          head_s;
    logic [OUT_W-1:0]          second_s;
    logic [CNT_W-1:0]          count_s;
    logic [CNT_W-1:0]          count_next_s;
    logic                      full_s;
    logic                      empty_s;
    wr_state_e                 state_r;
    wr_state_e                 state_next_s;
    logic [OUT_W-1:0]          wdata_next_s;
    logic                      in_ready_r;
    logic                      avm_write_r;
    logic [OUT_W-1:0]          avm_writedata_r;
    logic [15:0]               words_written_r;

    // Sample acceptance, group averaging and word assembly
    always_comb begin
        accept_s     = in_valid & in_ready_r & enable;
        group_done_s = accept_s & (&grp_cnt_r);
        sample_ext_s = {{DECIM_LOG2{in_data[SAMPLE_W-1]}}, in_data};
        sum_s        = acc_r + sample_ext_s;
        avg_s        = SAMPLE_W'(sum_s >>> DECIM_LOG2);
        push_s       = group_done_s & half_valid_r & ~full_s;
        push_word_s  = {avg_s, half_r};
        pop_s        = (state_r == WRITE) & ~avm_waitrequest;
        count_next_s = count_s + CNT_W'(push_s) - CNT_W'(pop_s);
    end

    // Accumulator, group counter and half-word packer; enable=0 drops partials
    always_ff @(posedge wrclock) begin
        if (wrreset || !enable) begin
            acc_r        <= '0;
            grp_cnt_r    <= '0;
            half_r       <= '0;
            half_valid_r <= 1'b0;
        end else if (accept_s) begin
            if (group_done_s) begin
                acc_r     <= '0;
                grp_cnt_r <= '0;
                if (half_valid_r) begin
                    half_valid_r <= 1'b0;
                end else begin
                    half_r       <= avg_s;
                    half_valid_r <= 1'b1;
                end
            end else begin
                acc_r     <= sum_s;
                grp_cnt_r <= grp_cnt_r + DECIM_LOG2'(1'b1);
            end
        end
    end

    fifo_decimation_word_buffer #(
        .DEPTH (BUF_DEPTH),
        .W     (OUT_W)
    ) u_word_buffer (
        .clk       (wrclock),
        .rst       (wrreset),
        .push      (push_s),
        .push_data (push_word_s),
        .pop       (pop_s),
        .head      (head_s),
        .second    (second_s),
        .count     (count_s),
        .full      (full_s),
        .empty     (empty_s)
    );

    // Write sequencer: preloads the next word so back-to-back writes need no gap
    always_comb begin
        state_next_s = state_r;
        wdata_next_s = avm_writedata_r;
        case (state_r)
            IDLE: begin
                if (!empty_s) begin
                    state_next_s = WRITE;
                    wdata_next_s = head_s;
                end else begin
                    state_next_s = IDLE;
                end
            end
            WRITE: begin
                if (avm_waitrequest) begin
                    state_next_s = WRITE;
                end else if (count_s > CNT_W'(1'b1)) begin
                    state_next_s = WRITE;
                    wdata_next_s = second_s;
                end else if (push_s) begin
                    state_next_s = WRITE;
                    wdata_next_s = push_word_s;
                end else begin
                    state_next_s = IDLE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
    end

    // Sequencer state and registered bus-side outputs
    always_ff @(posedge wrclock) begin
        if (wrreset) begin
            state_r         <= IDLE;
            avm_write_r     <= 1'b0;
            avm_writedata_r <= '0;
            words_written_r <= 16'd0;
            in_ready_r      <= 1'b0;
        end else begin
            state_r         <= state_next_s;
            avm_write_r     <= (state_next_s == WRITE);
            avm_writedata_r <= wdata_next_s;
            in_ready_r      <= enable & (count_next_s < CNT_W'(BUF_DEPTH));
            if (pop_s) begin
                words_written_r <= words_written_r + 16'd1;
            end
        end
    end

    assign in_ready      = in_ready_r;
    assign avm_write     = avm_write_r;
    assign avm_writedata = avm_writedata_r;
    assign words_written = words_written_r;

endmodule
